// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: FSM encoding and divider constants.
package hilo_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } hilo_state_t;

   localparam int unsigned DIV_CYCLES = 32;
   localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

   // Quotient reported for any division by zero, signed or unsigned.
   localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_unit_if.sv
// Decoder/multiplier-facing bus of the HI/LO unit.
interface hilo_unit_if #(parameter int unsigned WIDTH = 32);

   logic               hiwrite;
   logic               lowrite;
   logic               hiorlo;
   logic [WIDTH-1:0]   wdata;
   logic               hilo_we;
   logic [2*WIDTH-1:0] hilo_wdata;
   logic               div_start;
   logic               div_signed;
   logic [WIDTH-1:0]   div_a;
   logic [WIDTH-1:0]   div_b;
   logic               annul;
   logic               stall;
   logic               div_done;
   logic [WIDTH-1:0]   hi_o;
   logic [WIDTH-1:0]   lo_o;
   logic [WIDTH-1:0]   rdata;

   modport master (
      output hiwrite, lowrite, hiorlo, wdata, hilo_we, hilo_wdata,
             div_start, div_signed, div_a, div_b, annul,
      input  stall, div_done, hi_o, lo_o, rdata
   );

   modport slave (
      input  hiwrite, lowrite, hiorlo, wdata, hilo_we, hilo_wdata,
             div_start, div_signed, div_a, div_b, annul,
      output stall, div_done, hi_o, lo_o, rdata
   );

endinterface

// File: rtl/hilo_unit_div_core.sv
// div_core: restoring divider on operand magnitudes, one quotient bit per cycle.
// done/quotient/remainder are presented during the final iteration cycle.
module div_core
   import hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] a_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             dbz_q;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;
   logic             last;

   assign mag_a = (is_signed & a[WIDTH-1]) ? -a : a;
   assign mag_b = (is_signed & b[WIDTH-1]) ? -b : b;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_n   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
   end

   assign last = (cnt_q == CNT_W'(DIV_CYCLES - 1));
   assign done = busy_q & ~abort & last;

   // Sign fix-up and divide-by-zero override on the final-step values.
   always_comb begin
      if (dbz_q) begin
         quotient  = WIDTH'(DIV_ZERO_QUO);
         remainder = a_q;
      end else begin
         quotient  = qneg_q ? -quo_n : quo_n;
         remainder = rneg_q ? -rem_n : rem_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         a_q    <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= mag_a;
         dvs_q  <= mag_b;
         a_q    <= a;
         qneg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         rneg_q <= is_signed & a[WIDTH-1];
         dbz_q  <= (b == '0);
      end else if (busy_q) begin
         if (abort || last) begin
            busy_q <= 1'b0;
         end
         cnt_q <= cnt_q + CNT_W'(1);
         rem_q <= rem_n;
         quo_q <= quo_n;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with MTHI/MTLO/MFHI/MFLO, multiplier write and
// iterative DIV/DIVU. Optional macro HILO_BYPASS_EN forwards same-cycle writes to rdata.
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic      clk,
   input  logic      resetn,
   hilo_unit_if.slave bus
);

   hilo_state_t      state_q;
   hilo_state_t      state_n;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] rdata_c;

   logic             core_start;
   logic             core_abort;
   logic             core_done;
   logic [WIDTH-1:0] core_quo;
   logic [WIDTH-1:0] core_rem;
   logic             stall_c;

   div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk       (clk),
      .resetn    (resetn),
      .start     (core_start),
      .abort     (core_abort),
      .is_signed (bus.div_signed),
      .a         (bus.div_a),
      .b         (bus.div_b),
      .done      (core_done),
      .quotient  (core_quo),
      .remainder (core_rem)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Division handshake; annul wins over completion in the final BUSY cycle.
   always_comb begin
      state_n    = state_q;
      core_start = 1'b0;
      core_abort = 1'b0;
      stall_c    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.div_start && !bus.annul) begin
               state_n    = ST_BUSY;
               core_start = 1'b1;
               stall_c    = 1'b1;
            end
         end
         ST_BUSY: begin
            stall_c = 1'b1;
            if (bus.annul) begin
               state_n    = ST_IDLE;
               core_abort = 1'b1;
            end else if (core_done) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // HI/LO registers: division result in BUSY, otherwise multiplier then MTHI/MTLO.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state_q == ST_BUSY) begin
         if (core_done && !bus.annul) begin
            hi_q <= core_rem;
            lo_q <= core_quo;
         end
      end else if (bus.hilo_we) begin
         hi_q <= bus.hilo_wdata[2*WIDTH-1:WIDTH];
         lo_q <= bus.hilo_wdata[WIDTH-1:0];
      end else begin
         if (bus.hiwrite) begin
            hi_q <= bus.wdata;
         end
         if (bus.lowrite) begin
            lo_q <= bus.wdata;
         end
      end
   end

   always_comb begin
      rdata_c = bus.hiorlo ? lo_q : hi_q;
`ifdef HILO_BYPASS_EN
      if (state_q != ST_BUSY) begin
         if (bus.hilo_we) begin
            rdata_c = bus.hiorlo ? bus.hilo_wdata[WIDTH-1:0] : bus.hilo_wdata[2*WIDTH-1:WIDTH];
         end else if (bus.hiorlo ? bus.lowrite : bus.hiwrite) begin
            rdata_c = bus.wdata;
         end
      end
`endif
   end

   assign bus.stall    = stall_c;
   assign bus.div_done = (state_q == ST_DONE);
   assign bus.hi_o     = hi_q;
   assign bus.lo_o     = lo_q;
   assign bus.rdata    = rdata_c;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed division table, random divisions
// against an arithmetic reference, and hand-written annul/reset/write/bypass sequences.
module tb_hilo_unit;

   logic clk;
   logic resetn;
   int   n_cmp;
   int   n_err;

   hilo_unit_if #(.WIDTH(32)) bif ();

   hilo_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } div_vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer division with the architectural special cases.
   function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
   endfunction

   task automatic idle_inputs();
      bif.hiwrite    = 1'b0;
      bif.lowrite    = 1'b0;
      bif.hiorlo     = 1'b0;
      bif.wdata      = '0;
      bif.hilo_we    = 1'b0;
      bif.hilo_wdata = '0;
      bif.div_start  = 1'b0;
      bif.div_signed = 1'b0;
      bif.div_a      = '0;
      bif.div_b      = '0;
      bif.annul      = 1'b0;
   endtask

   task automatic run_div(input string nm, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
      int lat;
      int scnt;
      @(negedge clk);
      bif.div_start  = 1'b1;
      bif.div_signed = sgn;
      bif.div_a      = a;
      bif.div_b      = b;
      #1 scnt = bif.stall ? 1 : 0;
      @(negedge clk);
      bif.div_start  = 1'b0;
      bif.div_signed = ~sgn;
      bif.div_a      = $urandom;
      bif.div_b      = $urandom;
      lat = 1;
      #1;
      while (!bif.div_done && lat < 40) begin
         if (bif.stall) scnt++;
         @(negedge clk);
         #1 lat++;
      end
      check({nm, " latency"}, 64'(lat), 64'(33));
      check({nm, " stall cycles"}, 64'(scnt), 64'(33));
      check({nm, " stall at done"}, 64'(bif.stall), 64'(0));
      check({nm, " LO"}, 64'(bif.lo_o), 64'(eq));
      check({nm, " HI"}, 64'(bif.hi_o), 64'(er));
      bif.hiorlo = 1'b1;
      #1 check({nm, " rdata LO"}, 64'(bif.rdata), 64'(eq));
      bif.hiorlo = 1'b0;
      @(negedge clk);
      #1 check({nm, " done pulse width"}, 64'(bif.div_done), 64'(0));
   endtask

   task automatic preset_hilo(input logic [31:0] v);
      @(negedge clk);
      bif.hiwrite = 1'b1;
      bif.lowrite = 1'b1;
      bif.wdata   = v;
      @(negedge clk);
      bif.hiwrite = 1'b0;
      bif.lowrite = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      div_vec_t    vecs[$];
      logic [31:0] eq;
      logic [31:0] er;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      int          seen;
      int          lat;

      n_cmp  = 0;
      n_err  = 0;
      resetn = 1'b0;
      idle_inputs();

      vecs.push_back('{"divu 100/7",       1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002});
      vecs.push_back('{"div -7/2",         1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF});
      vecs.push_back('{"div ovf",          1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000});
      vecs.push_back('{"divu 5/0",         1'b0, 32'd5,          32'd0,          32'hFFFFFFFF, 32'h00000005});
      vecs.push_back('{"div 5/0",          1'b1, 32'd5,          32'd0,          32'hFFFFFFFF, 32'h00000005});
      vecs.push_back('{"div -7/0",         1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF, 32'hFFFFFFF9});
      vecs.push_back('{"divu max/1",       1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000});
      vecs.push_back('{"div 7/-2",         1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001});
      vecs.push_back('{"divu 80000000/-1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000});
      vecs.push_back('{"div -100/-7",      1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE});

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      check("reset hi", 64'(bif.hi_o), 64'(0));
      check("reset lo", 64'(bif.lo_o), 64'(0));
      check("reset rdata", 64'(bif.rdata), 64'(0));
      check("reset stall", 64'(bif.stall), 64'(0));
      check("reset div_done", 64'(bif.div_done), 64'(0));
      resetn = 1'b1;

      foreach (vecs[i]) run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

      for (int i = 0; i < 30; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 5))
            0: b = b >> $urandom_range(1, 31);
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            3: b = 32'd0;
            4: a = 32'h80000000;
            default: ;
         endcase
         ref_div(sgn, a, b, eq, er);
         run_div($sformatf("rand%0d", i), sgn, a, b, eq, er);
      end

      // Annul mid-division; writes during BUSY are ignored.
      preset_hilo(32'h11111111);
      @(negedge clk);
      bif.div_start = 1'b1; bif.div_signed = 1'b0; bif.div_a = 32'd100; bif.div_b = 32'd7;
      @(negedge clk);
      bif.div_start = 1'b0; bif.hiwrite = 1'b1; bif.lowrite = 1'b1; bif.wdata = 32'hDEADBEEF;
      bif.hilo_we = 1'b1; bif.hilo_wdata = 64'hCAFEF00D_0BADF00D;
      seen = 0;
      repeat (9) begin
         @(negedge clk);
         idle_inputs();
         #1 if (bif.div_done) seen++;
      end
      bif.annul = 1'b1;
      #1 check("annul cycle stall", 64'(bif.stall), 64'(1));
      @(negedge clk);
      bif.annul = 1'b0;
      #1;
      check("annul stall released", 64'(bif.stall), 64'(0));
      check("annul hi kept", 64'(bif.hi_o), 64'(32'h11111111));
      check("annul lo kept", 64'(bif.lo_o), 64'(32'h11111111));
      repeat (30) begin
         @(negedge clk);
         #1 if (bif.div_done) seen++;
      end
      check("annul no div_done", 64'(seen), 64'(0));
      check("annul hi later", 64'(bif.hi_o), 64'(32'h11111111));

      // Reset mid-division.
      preset_hilo(32'h11111111);
      @(negedge clk);
      bif.div_start = 1'b1; bif.div_signed = 1'b0; bif.div_a = 32'd100; bif.div_b = 32'd7;
      @(negedge clk);
      bif.div_start = 1'b0;
      repeat (9) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("rst mid hi", 64'(bif.hi_o), 64'(0));
      check("rst mid lo", 64'(bif.lo_o), 64'(0));
      check("rst mid stall", 64'(bif.stall), 64'(0));
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         #1 if (bif.div_done || bif.stall) seen++;
      end
      check("rst mid idle", 64'(seen), 64'(0));
      run_div("post reset divu 100/7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);

      // div_start held through DONE is ignored; next division begins the cycle after.
      @(negedge clk);
      bif.div_start = 1'b1; bif.div_signed = 1'b0; bif.div_a = 32'd1000; bif.div_b = 32'd10;
      lat = 0;
      @(negedge clk);
      #1 lat = 1;
      while (!bif.div_done && lat < 40) begin
         @(negedge clk);
         #1 lat++;
      end
      check("b2b first latency", 64'(lat), 64'(33));
      check("b2b stall in done", 64'(bif.stall), 64'(0));
      check("b2b first LO", 64'(bif.lo_o), 64'(100));
      @(negedge clk);
      bif.div_a = 32'd81; bif.div_b = 32'd9;
      #1 check("b2b restart stall", 64'(bif.stall), 64'(1));
      @(negedge clk);
      bif.div_start = 1'b0;
      #1 lat = 1;
      while (!bif.div_done && lat < 40) begin
         @(negedge clk);
         #1 lat++;
      end
      check("b2b second latency", 64'(lat), 64'(33));
      check("b2b second LO", 64'(bif.lo_o), 64'(9));
      check("b2b second HI", 64'(bif.hi_o), 64'(0));

      // Multiplier write has priority over MTHI/MTLO.
      @(negedge clk);
      bif.hiwrite = 1'b1; bif.lowrite = 1'b1; bif.wdata = 32'hAAAAAAAA;
      bif.hilo_we = 1'b1; bif.hilo_wdata = 64'h12345678_9ABCDEF0;
      @(negedge clk);
      idle_inputs();
      #1;
      check("prio hi", 64'(bif.hi_o), 64'(32'h12345678));
      check("prio lo", 64'(bif.lo_o), 64'(32'h9ABCDEF0));

      // Independent MTHI only.
      @(negedge clk);
      bif.hiwrite = 1'b1; bif.wdata = 32'h0F0F0F0F;
      @(negedge clk);
      idle_inputs();
      #1;
      check("mthi hi", 64'(bif.hi_o), 64'(32'h0F0F0F0F));
      check("mthi lo untouched", 64'(bif.lo_o), 64'(32'h9ABCDEF0));

      // MTLO then MFLO: same-cycle forwarding only in the bypass build.
      @(negedge clk);
      bif.lowrite = 1'b1; bif.wdata = 32'h5A5A5A5A; bif.hiorlo = 1'b1;
`ifdef HILO_BYPASS_EN
      #1 check("mtlo same-cycle rdata", 64'(bif.rdata), 64'(32'h5A5A5A5A));
`else
      #1 check("mtlo same-cycle rdata", 64'(bif.rdata), 64'(32'h9ABCDEF0));
`endif
      @(negedge clk);
      bif.lowrite = 1'b0;
      #1 check("mtlo next-cycle rdata", 64'(bif.rdata), 64'(32'h5A5A5A5A));

      // Multiplier write then MFHI in the same cycle.
      @(negedge clk);
      bif.hilo_we = 1'b1; bif.hilo_wdata = 64'hFEDCBA98_76543210; bif.hiorlo = 1'b0;
`ifdef HILO_BYPASS_EN
      #1 check("mul same-cycle rdata", 64'(bif.rdata), 64'(32'hFEDCBA98));
`else
      #1 check("mul same-cycle rdata", 64'(bif.rdata), 64'(32'h0F0F0F0F));
`endif
      @(negedge clk);
      idle_inputs();
      #1 check("mul next-cycle rdata", 64'(bif.rdata), 64'(32'hFEDCBA98));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register file plus iterative divider, directly downstream of the main decoder. Consumes the decoder's `hiwrite`, `lowrite` and `hiorlo` controls for MTHI/MTLO/MFHI/MFLO. Runs DIV/DIVU as a 32-iteration sequential operation and stalls the pipeline until HI/LO are valid. Also accepts a 64-bit HI/LO write from the external multiplier.

## Interface

Parameters:
- `WIDTH`, 32, operand/register width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `hiwrite`  in  1  MTHI write enable (from decoder).
- `lowrite`  in  1  MTLO write enable (from decoder).
- `hiorlo`  in  1  read select: 0 = HI (MFHI), 1 = LO (MFLO).
- `wdata`  in  WIDTH  MTHI/MTLO source (rs value).
- `hilo_we`  in  1  multiplier result write.
- `hilo_wdata`  in  2*WIDTH  {HI, LO} from multiplier.
- `div_start`  in  1  begin DIV/DIVU; sampled only in IDLE.
- `div_signed`  in  1  1 = DIV, 0 = DIVU.
- `div_a`, `div_b`  in  WIDTH  dividend, divisor.
- `annul`  in  1  flush; aborts an in-flight division.
- `stall`  out  1  hold pipeline.
- `div_done`  out  1  one-cycle pulse: HI/LO hold the new quotient/remainder.
- `hi_o`, `lo_o`  out  WIDTH  register contents.
- `rdata`  out  WIDTH  `hiorlo ? LO : HI`.

## Operation

- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on `div_start & ~annul`; operands are latched on that edge.
  - BUSY → DONE after 32 iterations; HI/LO are written on that edge.
  - BUSY → IDLE on `annul`; no HI/LO write.
  - DONE → IDLE unconditionally.
- Division algorithm:
  - Restoring, one quotient bit per cycle, on operand magnitudes.
  - Signed mode: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - Result: LO = quotient, HI = remainder.
- Divide by zero: HI = `div_a`, LO = 0xFFFFFFFF, for both signed and unsigned.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- Writes in IDLE/DONE:
  - `hilo_we` has priority and writes both registers.
  - Otherwise `hiwrite` writes HI and `lowrite` writes LO; the two are independent.
- In BUSY, `hiwrite`, `lowrite`, `hilo_we` and `div_start` are ignored.
- Reset: state IDLE, HI = LO = 0, iteration counter = 0. Outputs `stall` = 0, `div_done` = 0, `rdata` = 0. Reset mid-division discards it with no write.

## Timing

- `div_start` accepted at cycle T; BUSY occupies T+1..T+32.
- DONE at T+33: `div_done` = 1 and HI/LO already hold the result.
- `stall` = `(IDLE & div_start & ~annul) | BUSY`. High for 33 cycles (T..T+32), low from T+33.
- `annul` in BUSY at cycle k: state IDLE at k+1, `stall` low at k+1, HI/LO unchanged.
- `div_start` in the DONE cycle is ignored; a back-to-back division starts from IDLE at T+34 at the earliest.
- Register writes take effect on the clock edge; `hi_o`/`lo_o` show the new value the following cycle.
- `rdata` is combinational from the registers (see Configuration).

## Configuration

- `HILO_BYPASS_EN` defined: `rdata` forwards same-cycle write data.
  - `hilo_we` → corresponding half of `hilo_wdata`.
  - `hiwrite`/`lowrite` → `wdata`, for the selected register.
  - Lets MFHI/MFLO immediately after MTHI/MTLO or a multiply see the new value.
- Undefined: `rdata` reflects registered HI/LO only; the hazard is resolved by the pipeline.

## Structure

- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2).
  - `DIV_CYCLES` = 32.
  - Divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, `div_core`:
  - Owns magnitude conversion, the shift/subtract datapath, the iteration counter, and sign fix-up.
  - Interface: `start`, `abort`, `done`, `quotient`, `remainder`.
- Top level owns the FSM handshake, HI/LO registers, write priority and the read mux.

## Test plan

- DIVU 100 / 7 at T → `stall` high T..T+32; at T+33 `div_done` = 1, LO = 0x0000000E, HI = 0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → HI = 0x00000005, LO = 0xFFFFFFFF after 33 cycles.
- Start DIVU with HI = LO = 0x11111111; `annul` at T+10 → `stall` low at T+11, HI/LO still 0x11111111, no `div_done`. Repeat with `resetn` low at T+10 → HI = LO = 0, state IDLE.
- `hiwrite` + `lowrite` + `hilo_we` same cycle, `wdata` = 0xAAAAAAAA, `hilo_wdata` = 0x12345678_9ABCDEF0 → HI = 0x12345678, LO = 0x9ABCDEF0.
- MTLO 0x5A5A5A5A with `hiorlo` = 1 in the same cycle → `rdata` = 0x5A5A5A5A that cycle only when `HILO_BYPASS_EN` is defined, otherwise the old LO; next cycle `rdata` = 0x5A5A5A5A in both builds.
